// File: rtl/sqrt_seq.sv
// Sequential integer square root: keeps an operand x that can be loaded or stepped by delta,
// and recomputes floor(sqrt(x)) with a one-bit-per-cycle digit recurrence after every change.
module sqrt_seq #(
    parameter int WIDTH = 32,
    parameter bit WRAP  = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               next,
    input  logic               previous,
    input  logic [WIDTH-1:0]   n,
    input  logic [WIDTH-1:0]   delta,
    output logic [WIDTH-1:0]   x,
    output logic [WIDTH/2-1:0] root,
    output logic               valid,
    output logic               busy,
    output logic               ovf
);

    localparam int HW = WIDTH / 2;
    localparam int RW = HW + 3;
    localparam int CW = (HW > 1) ? $clog2(HW) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nx;
    logic [WIDTH-1:0] opnd;
    logic [RW-1:0]    rem, rem_sh, rem_nx, trial;
    logic [HW-1:0]    q, q_nx;
    logic [CW-1:0]    cnt;

    logic             start, step, range_err;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff, x_step, x_new;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Load wins everywhere; a step is only taken from DONE and only with exactly one direction.
    always_comb begin
        start    = load;
        step     = 1'b0;
        state_nx = state;
        if (!load && state == DONE && (next ^ previous)) step = 1'b1;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (start) state_nx = CALC;
                     else if (cnt == '0) state_nx = DONE;
            DONE:    if (start || step) state_nx = CALC;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sum       = {1'b0, x} + {1'b0, delta};
        diff      = x - delta;
        range_err = 1'b0;
        x_step    = x;
        if (next) begin
            range_err = sum[WIDTH];
            x_step    = (range_err && !WRAP) ? '1 : sum[WIDTH-1:0];
        end else begin
            range_err = (delta > x);
            x_step    = (range_err && !WRAP) ? '0 : diff;
        end
        x_new = load ? n : x_step;
    end

    // Bring down the next two operand bits and try subtracting 4*q+1 from the partial remainder.
    always_comb begin
        rem_sh = (rem << 2) | {{(RW-2){1'b0}}, opnd[WIDTH-1:WIDTH-2]};
        trial  = {1'b0, q, 2'b01};
        rem_nx = rem_sh;
        q_nx   = {q[HW-2:0], 1'b0};
        if (rem_sh >= trial) begin
            rem_nx = rem_sh - trial;
            q_nx   = {q[HW-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x    <= '0;
            opnd <= '0;
            rem  <= '0;
            q    <= '0;
            cnt  <= '0;
            root <= '0;
            ovf  <= 1'b0;
        end else if (start || step) begin
            x    <= x_new;
            opnd <= x_new;
            rem  <= '0;
            q    <= '0;
            cnt  <= CW'(HW - 1);
            if (start)          ovf <= 1'b0;
            else if (range_err) ovf <= 1'b1;
        end else if (state == CALC) begin
            opnd <= opnd << 2;
            rem  <= rem_nx;
            q    <= q_nx;
            if (cnt == '0) root <= q_nx;
            else           cnt  <= cnt - 1'b1;
        end
    end

    assign busy  = (state == CALC);
    assign valid = (state == DONE);

endmodule

// File: tb/tb_sqrt_seq.sv
// Scoreboard bench for sqrt_seq: a saturating and a wrapping instance share stimulus,
// expected results are queued at issue time and popped by monitors on each rising valid.
module tb_sqrt_seq;

    logic        clk = 1'b0;
    logic        reset, load, next, previous;
    logic [31:0] n, delta;

    logic [31:0] x0, x1;
    logic [15:0] root0, root1;
    logic        valid0, valid1, busy0, busy1, ovf0, ovf1;

    typedef struct packed {
        logic [31:0] x;
        logic [15:0] root;
        logic        ovf;
    } result_t;

    result_t exp_sat[$];
    result_t exp_wrap[$];
    result_t e0, e1;
    logic    prev_valid0 = 1'b0;
    logic    prev_valid1 = 1'b0;
    int      n_vectors = 0;
    int      n_miscompares = 0;

    sqrt_seq #(.WIDTH(32), .WRAP(1'b0)) dut_sat (
        .clk(clk), .reset(reset), .load(load), .next(next), .previous(previous),
        .n(n), .delta(delta), .x(x0), .root(root0), .valid(valid0), .busy(busy0), .ovf(ovf0)
    );

    sqrt_seq #(.WIDTH(32), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .reset(reset), .load(load), .next(next), .previous(previous),
        .n(n), .delta(delta), .x(x1), .root(root1), .valid(valid1), .busy(busy1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
        n_vectors++;
        if (actual !== required) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    task automatic apply_stimulus(input logic ld, input logic nx, input logic pv,
                                  input logic [31:0] nv, input logic [31:0] dv);
        load     = ld;
        next     = nx;
        previous = pv;
        n        = nv;
        delta    = dv;
    endtask

    task automatic expect_result(input logic [31:0] xs, input logic [15:0] rs, input logic os,
                                 input logic [31:0] xw, input logic [15:0] rw, input logic ow);
        exp_sat.push_back('{x: xs, root: rs, ovf: os});
        exp_wrap.push_back('{x: xw, root: rw, ovf: ow});
    endtask

    // Counts edges from the current point until valid is seen; zero means it never came.
    task automatic wait_result(input string name, input int expected_lat);
        int lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (valid0) begin
                lat = i;
                break;
            end
        end
        check_output({name, " latency"}, lat, expected_lat);
    endtask

    task automatic run_command(input string name, input logic ld, input logic nx, input logic pv,
                               input logic [31:0] nv, input logic [31:0] dv);
        apply_stimulus(ld, nx, pv, nv, dv);
        @(posedge clk);
        #2;
        apply_stimulus(1'b0, 1'b0, 1'b0, nv, dv);
        check_output({name, " valid drop"}, valid0, 1'b0);
        check_output({name, " busy"}, busy0, 1'b1);
        wait_result(name, 16);
    endtask

    always @(negedge clk) begin
        if (valid0 && !prev_valid0) begin
            if (exp_sat.size() == 0) begin
                n_vectors++;
                n_miscompares++;
                $display("[TB] FAIL sat unexpected result: x=0x%0h root=0x%0h", x0, root0);
            end else begin
                e0 = exp_sat.pop_front();
                check_output("sat x", x0, e0.x);
                check_output("sat root", root0, e0.root);
                check_output("sat ovf", ovf0, e0.ovf);
            end
        end
        if (valid1 && !prev_valid1) begin
            if (exp_wrap.size() == 0) begin
                n_vectors++;
                n_miscompares++;
                $display("[TB] FAIL wrap unexpected result: x=0x%0h root=0x%0h", x1, root1);
            end else begin
                e1 = exp_wrap.pop_front();
                check_output("wrap x", x1, e1.x);
                check_output("wrap root", root1, e1.root);
                check_output("wrap ovf", ovf1, e1.ovf);
            end
        end
        prev_valid0 = valid0;
        prev_valid1 = valid1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b0;
        #3;
        check_output("reset x", x0, 32'd0);
        check_output("reset root", root0, 16'd0);
        check_output("reset valid", valid0, 1'b0);
        check_output("reset busy", busy0, 1'b0);
        check_output("reset ovf", ovf0, 1'b0);

        // Release between edges with next present: it must be ignored in IDLE.
        @(posedge clk);
        #3;
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check_output("idle next busy", busy0, 1'b0);
        check_output("idle next x", x0, 32'd0);

        expect_result(32'd1, 16'd1, 1'b0, 32'd1, 16'd1, 1'b0);
        run_command("load_1", 1'b1, 1'b0, 1'b0, 32'd1, 32'd1);

        // Holding next steps once every 17 cycles; delta switches to 5 before the last step.
        expect_result(32'd2, 16'd1, 1'b0, 32'd2, 16'd1, 1'b0);
        expect_result(32'd3, 16'd1, 1'b0, 32'd3, 16'd1, 1'b0);
        expect_result(32'd4, 16'd2, 1'b0, 32'd4, 16'd2, 1'b0);
        expect_result(32'd9, 16'd3, 1'b0, 32'd9, 16'd3, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'd1, 32'd1);
        for (int k = 0; k < 4; k++) begin
            wait_result("next_hold", 17);
            if (k == 2) delta = 32'd5;
        end
        next = 1'b0;

        expect_result(32'hFFFF_FFFF, 16'hFFFF, 1'b0, 32'hFFFF_FFFF, 16'hFFFF, 1'b0);
        run_command("load_max", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd5);
        expect_result(32'hFFFF_FFFF, 16'hFFFF, 1'b1, 32'd4, 16'd2, 1'b1);
        run_command("next_ovf", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd5);

        expect_result(32'd3, 16'd1, 1'b0, 32'd3, 16'd1, 1'b0);
        run_command("load_3", 1'b1, 1'b0, 1'b0, 32'd3, 32'd5);
        expect_result(32'd0, 16'd0, 1'b1, 32'hFFFF_FFFE, 16'hFFFF, 1'b1);
        run_command("prev_unf", 1'b0, 1'b0, 1'b1, 32'd3, 32'd5);
        expect_result(32'd16, 16'd4, 1'b0, 32'd16, 16'd4, 1'b0);
        run_command("load_16", 1'b1, 1'b0, 1'b0, 32'd16, 32'd5);

        // next and previous together in DONE is a no-op.
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'd16, 32'd5);
        @(posedge clk);
        #1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'd16, 32'd5);
        repeat (2) @(posedge clk);
        #1;
        check_output("both valid", valid0, 1'b1);
        check_output("both busy", busy0, 1'b0);
        check_output("both x", x0, 32'd16);
        check_output("both root", root0, 16'd4);
        check_output("both wrap x", x1, 32'd16);

        // A load during CALC restarts; the abandoned operand never produces a result.
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'd50, 32'd5);
        @(posedge clk);
        #2;
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'd50, 32'd5);
        check_output("calc root hold", root0, 16'd4);
        check_output("calc x", x0, 32'd50);
        repeat (5) @(posedge clk);
        #2;
        expect_result(32'd100, 16'd10, 1'b0, 32'd100, 16'd10, 1'b0);
        run_command("load_abort", 1'b1, 1'b0, 1'b0, 32'd100, 32'd5);

        // Asynchronous reset in the middle of CALC.
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'd200, 32'd5);
        @(posedge clk);
        #2;
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'd200, 32'd5);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_output("async x", x0, 32'd0);
        check_output("async root", root0, 16'd0);
        check_output("async busy", busy0, 1'b0);
        check_output("async valid", valid0, 1'b0);
        check_output("async wrap x", x1, 32'd0);
        #2;
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'd5);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_output("post reset busy", busy0, 1'b0);
        check_output("post reset valid", valid0, 1'b0);
        check_output("post reset x", x0, 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd5);

        // A load present on the first edge after release is taken.
        @(posedge clk);
        #3;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        expect_result(32'd9, 16'd3, 1'b0, 32'd9, 16'd3, 1'b0);
        run_command("load_after_release", 1'b1, 1'b0, 1'b0, 32'd9, 32'd5);

        repeat (3) @(posedge clk);
        #1;
        check_output("sat queue drained", exp_sat.size(), 0);
        check_output("wrap queue drained", exp_wrap.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/sqrt_seq.md
SQRT_SEQ -- requirements
Module: sqrt_seq

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 32, setting the operand width; it must be even and at least 4.
REQ-002 The block SHALL have a parameter WRAP, default 0, selecting out-of-range handling: 0 = saturate, 1 = wrap modulo 2^WIDTH.
REQ-003 Port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port load, input, 1 bit: load the start operand from n and begin a computation.
REQ-006 Port next, input, 1 bit: step the operand up by delta.
REQ-007 Port previous, input, 1 bit: step the operand down by delta.
REQ-008 Port n, input, WIDTH bits: start operand.
REQ-009 Port delta, input, WIDTH bits: step size.
REQ-010 Port x, output, WIDTH bits: current operand.
REQ-011 Port root, output, WIDTH/2 bits: floor(sqrt(x)) of the last completed computation.
REQ-012 Port valid, output, 1 bit: root corresponds to x.
REQ-013 Port busy, output, 1 bit: a computation is in progress.
REQ-014 Port ovf, output, 1 bit: sticky out-of-range flag.

Function
REQ-015 The state machine SHALL have three states: IDLE (no result), CALC (iterating) and DONE (result valid).
REQ-016 Outputs SHALL decode from state as follows: busy=1 only in CALC; valid=1 only in DONE.
REQ-017 All inputs SHALL be level-sampled on the rising clk edge.
REQ-018 Command priority SHALL be load > next/previous.
REQ-019 When next and previous are high in the same cycle without load, the block SHALL treat it as a no-op.
REQ-020 IDLE SHALL accept load only; next and previous are ignored in IDLE.
REQ-021 DONE SHALL accept load, next or previous.
REQ-022 On an accepted load edge, the block SHALL set x<=n, clear ovf, and enter CALC.
REQ-023 On an accepted next edge, the block SHALL set x<=x+delta and enter CALC.
REQ-024 On an accepted previous edge, the block SHALL set x<=x-delta and enter CALC.
REQ-025 In CALC, next and previous SHALL be ignored; load SHALL abort the current computation and restart it with x<=n and ovf cleared.
REQ-026 The root SHALL be computed with the bit-by-bit (digit-recurrence) method, one result bit per cycle, over WIDTH/2 iterations, using an internal iteration counter.
REQ-027 Latency: valid SHALL rise exactly WIDTH/2 rising edges after the acceptance edge (16 for WIDTH=32).
REQ-028 valid SHALL drop at the acceptance edge.
REQ-029 root SHALL hold its previous value throughout CALC and update only on the edge that enters DONE.
REQ-030 The block SHALL stay in DONE until a command is accepted; with next held high, it SHALL step every WIDTH/2+1 cycles.
REQ-031 Overflow (x+delta > 2^WIDTH-1) SHALL set ovf=1; x SHALL become 2^WIDTH-1 if WRAP=0, or (x+delta) mod 2^WIDTH if WRAP=1.
REQ-032 Underflow (delta > x on previous) SHALL set ovf=1; x SHALL become 0 if WRAP=0, or (x-delta) mod 2^WIDTH if WRAP=1.
REQ-033 ovf SHALL remain set until a load or reset clears it.
REQ-034 delta=0 SHALL be legal: x is unchanged and the block recomputes.

Reset
REQ-035 While reset=0, the block SHALL force, immediately and independent of clk: state=IDLE, x=0, root=0, valid=0, busy=0, ovf=0, iteration counter=0.
REQ-036 Reset asserted mid-CALC SHALL discard the computation; after release the block SHALL wait in IDLE for load.
REQ-037 Commands present on the first edge after reset release SHALL be handled normally (load accepted; next/previous ignored).

Verification
REQ-038 WIDTH=32, WRAP=0: reset, then load with n=1, delta=1 -> busy=1 for 16 cycles, then valid=1, x=1, root=1.
REQ-039 Then hold next=1 -> successive results x=2,3,4,9 give root=1,1,2,3; valid pulses each 17 cycles.
REQ-040 load n=0xFFFFFFFF -> root=0xFFFF; then next with delta=5 -> WRAP=0: x=0xFFFFFFFF, ovf=1; WRAP=1: x=4, root=2, ovf=1.
REQ-041 load n=3, delta=5, then previous -> WRAP=0: x=0, root=0, ovf=1; a following load clears ovf.
REQ-042 In DONE, next and previous high together -> x, root and valid unchanged; load n=100 asserted mid-CALC -> restart, valid after 16 cycles with root=10.
REQ-043 reset=0 asserted between clock edges during CALC -> all outputs 0 immediately; next=1 after release -> remains IDLE.
